// File: rtl/types_pkg.sv
// Shared types for the load/store unit: data width, access-size encodings and FSM states.
package types_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_t;

  function automatic logic is_half(input logic [2:0] f);
    return (f == MEM_H) || (f == MEM_HU);
  endfunction

  function automatic logic is_word(input logic [2:0] f);
    return f == MEM_W;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half/word from a memory word and sign- or zero-extends it.
module load_align
  import types_pkg::*;
(
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_lo,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_word >> {i_lo, 3'b000};

  always_comb begin
    o_data = '0;
    case (mem_size_t'(i_funct3))
      MEM_B:   o_data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
      MEM_H:   o_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
      MEM_W:   o_data = i_word;
      MEM_BU:  o_data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
      MEM_HU:  o_data = {{(XLEN-16){1'b0}}, w_sh[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit with a word-organised data memory and programmable latency.
// LSU_MISALIGN_CHECK_EN: flag misaligned half/word accesses instead of force-aligning them.
//
// state | meaning
// IDLE  | waiting; a request is captured and Stall raised in the same cycle
// BUSY  | counting down LAT wait cycles; array access on the exit edge
// DONE  | ReadData/MisalignErr valid, core commits; back to IDLE
module load_store_unit
  import types_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData,
  output logic            Stall,
  output logic            MisalignErr
);

  localparam int AW = $clog2(DEPTH);

  lsu_state_t      r_state, w_next;
  logic [3:0]      r_cnt;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]      r_funct3;
  logic            r_store, r_misalign;
  logic            w_capture, w_access, w_stall, w_bad, w_we;
  logic [1:0]      w_lo;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_lanes, w_word, w_load;
  logic [AW-1:0]   w_idx;
  logic            w_unused;
  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_access  = 1'b0;
    w_stall   = 1'b0;
    case (r_state)
      IDLE: if (MemRead | MemWrite) begin
        w_capture = 1'b1;
        w_stall   = 1'b1;
        w_next    = BUSY;
      end
      BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_access = 1'b1;
          w_next   = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Gated so Stall falls the instant Reset rises, even with a request still on the inputs.
  assign Stall = w_stall & ~Reset;

`ifdef LSU_MISALIGN_CHECK_EN
  assign w_lo  = r_addr[1:0];
  assign w_bad = (is_half(r_funct3) && r_addr[0]) || (is_word(r_funct3) && (r_addr[1:0] != 2'b00));
`else
  always_comb begin
    w_lo = r_addr[1:0];
    if (is_half(r_funct3))      w_lo = {r_addr[1], 1'b0};
    else if (is_word(r_funct3)) w_lo = 2'b00;
  end
  assign w_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= 3'b000;
      r_store    <= 1'b0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (w_capture) begin
        r_addr   <= Addr;
        r_wdata  <= WriteData;
        r_funct3 <= Funct3;
        r_store  <= MemWrite;
        r_cnt    <= 4'(LAT);
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_misalign <= w_access & w_bad;
      if (w_access && !r_store) r_rdata <= w_bad ? '0 : w_load;
    end
  end

  assign ReadData    = r_rdata;
  assign MisalignErr = r_misalign;

  // Upper address bits are ignored so the memory wraps modulo DEPTH*4 bytes.
  assign w_idx    = r_addr[AW+1:2];
  assign w_unused = ^r_addr[XLEN-1:AW+2];
  assign w_word   = r_mem[w_idx];

  always_comb begin
    w_be    = 4'b0000;
    w_lanes = r_wdata;
    case (mem_size_t'(r_funct3))
      MEM_B: begin
        w_be    = 4'b0001 << w_lo;
        w_lanes = {4{r_wdata[7:0]}};
      end
      MEM_H: begin
        w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
        w_lanes = {2{r_wdata[15:0]}};
      end
      MEM_W:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_we = w_access & r_store & ~w_bad;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lanes[8*b +: 8];
      end
    end
  end

  load_align u_load_align (
    .i_word   (w_word),
    .i_lo     (w_lo),
    .i_funct3 (r_funct3),
    .o_data   (w_load)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level memory model plus per-cycle output compare.
module tb_load_store_unit;
  import types_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        MisalignErr;

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Addr        (Addr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .MisalignErr (MisalignErr)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] exp_rd = '0;
  logic        active = 1'b0;
  int          issue_cyc = 0;
  logic        op_load = 1'b0;
  logic        op_mis = 1'b0;
  logic [31:0] op_rd_val = '0;
  int          stall_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic mis(input logic [31:0] a, input logic [2:0] f);
`ifdef LSU_MISALIGN_CHECK_EN
    int n = size_of(f);
    return (n > 1) && ((a % n) != 0);
`else
    return (a != a) && (f != f);
`endif
  endfunction

  function automatic int eff_addr(input logic [31:0] a, input logic [2:0] f);
    int n = size_of(f);
    int e = int'(a & 32'(DEPTH*4 - 1));
    if (n > 0) e = e - (e % n);
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f);
    int n = size_of(f);
    int e;
    logic [31:0] v = '0;
    logic [31:0] w;
    if (n == 0 || mis(a, f)) return '0;
    e = eff_addr(a, f);
    for (int i = 0; i < n; i++) begin
      w = m_mem[(e + i) / 4] >> (8 * ((e + i) % 4));
      v = v | ({24'h0, w[7:0]} << (8 * i));
    end
    if (f == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
    if (f == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    int n = size_of(f);
    int e;
    if (n == 0 || mis(a, f)) return;
    e = eff_addr(a, f);
    for (int i = 0; i < n; i++) m_mem[(e + i) / 4][8*((e + i) % 4) +: 8] = d[8*i +: 8];
  endtask

  // Returns during the DONE cycle, 2 time units after the edge that entered it.
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; Funct3 = f; Addr = a; WriteData = d;
    issue_cyc = cyc;
    stall_run = 0;
    op_load = rd && !wr;
    op_mis = mis(a, f);
    if (op_load) op_rd_val = m_load(a, f);
    else if (wr) m_store(a, f, d);
    active = 1'b1;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    int d;
    logic es, ed;
    if (Reset) begin
      exp_rd = '0;
      active = 1'b0;
    end
    d  = cyc - issue_cyc;
    es = active && (d <= LAT + 1);
    ed = active && (d == LAT + 2);
    if (ed && op_load) exp_rd = op_rd_val;
    if (active && d >= 1 && Stall) stall_run++;
    chk("stall", 32'(Stall), 32'(es));
    chk("read_data", ReadData, exp_rd);
    chk("misalign", 32'(MisalignErr), 32'(ed && op_mis));
    if (ed) active = 1'b0;
  end

  initial begin
    foreach (m_mem[i]) m_mem[i] = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_stall", 32'(Stall), 32'h0);
    chk("reset_rdata", ReadData, 32'h0);
    chk("reset_misalign", 32'(MisalignErr), 32'h0);
    @(posedge clk); #1;
    Reset = 1'b0;

    do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    do_op(1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    do_op(1'b0, 1'b1, 3'b010, 32'h40, 32'h0);

    do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_stall_cycles", 32'(stall_run), 32'd3);
    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_stall_cycles", 32'(stall_run), 32'd3);
    chk("lw_deadbeef", ReadData, 32'hDEADBEEF);
    chk("done_stall_low", 32'(Stall), 32'h0);

    do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    do_op(1'b0, 1'b1, 3'b000, 32'h13, 32'h00000080);
    chk("sb_keeps_rdata", ReadData, 32'hDEADBEEF);
    do_op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb_13", ReadData, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
    chk("lbu_13", ReadData, 32'h00000080);
    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_10_after_sb", ReadData, 32'h80000000);

    do_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h00008001);
    do_op(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_22", ReadData, 32'hFFFF8001);
    do_op(1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
    chk("lhu_22", ReadData, 32'h00008001);
    do_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("lw_20_after_sh", ReadData, 32'h80010000);

    do_op(1'b0, 1'b1, 3'b010, 32'h1000, 32'h12345678);
    do_op(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("lw_wrap", ReadData, 32'h12345678);

    // Reset in the middle of BUSY drops the store and clears the outputs.
    @(posedge clk); #1;
    MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h40; WriteData = 32'hAAAAAAAA;
    issue_cyc = cyc; active = 1'b1; op_load = 1'b0; op_mis = 1'b0;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    chk("stall_busy_pre_reset", 32'(Stall), 32'h1);
    #1 Reset = 1'b1;
    #1;
    chk("stall_async_reset", 32'(Stall), 32'h0);
    chk("rdata_async_reset", ReadData, 32'h0);
    active = 1'b0;
    @(posedge clk); #1;
    Reset = 1'b0;
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    chk("lw_40_after_reset", ReadData, 32'h0);

    do_op(1'b0, 1'b1, 3'b010, 32'h40, 32'h11223344);
    do_op(1'b1, 1'b0, 3'b010, 32'h41, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_41_misalign_flag", 32'(MisalignErr), 32'h1);
    chk("lw_41_rdata", ReadData, 32'h0);
`else
    chk("lw_41_misalign_flag", 32'(MisalignErr), 32'h0);
    chk("lw_41_rdata", ReadData, 32'h11223344);
`endif

    do_op(1'b1, 1'b0, 3'b001, 32'h23, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lh_23", ReadData, 32'h0);
`else
    chk("lh_23", ReadData, 32'hFFFF8001);
`endif

    do_op(1'b1, 1'b1, 3'b010, 32'h50, 32'hCAFEF00D);
    chk("rw_is_store_rdata_held", ReadData, m_load(32'h23, 3'b001));
    do_op(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
    chk("lw_50", ReadData, 32'hCAFEF00D);

    do_op(1'b0, 1'b1, 3'b011, 32'h10, 32'hFFFFFFFF);
    do_op(1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    chk("load_unsupported", ReadData, 32'h0);
    do_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("store_unsupported_no_write", ReadData, 32'h80000000);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
